// File: rtl/iomem_bellek_yanitlayici_pkg.sv
// Shared constants for the iomem responder: FSM encodings, port indices,
// address range and the read strobe encoding.
package iomem_bellek_yanitlayici_pkg;

    localparam logic [1:0] BOSTA  = 2'd0;
    localparam logic [1:0] ERISIM = 2'd1;
    localparam logic [1:0] AL     = 2'd2;
    localparam logic [1:0] YANIT  = 2'd3;

    localparam logic BIB_PORT  = 1'b0;
    localparam logic VERI_PORT = 1'b1;

    localparam int ADR_MSB = 18;
    localparam int ADR_LSB = 2;
    localparam int ADR_W   = ADR_MSB - ADR_LSB + 1;

    localparam logic [3:0] WSTRB_OKU = 4'b0000;

endpackage

// File: rtl/iomem_bellek_yanitlayici_hakem.sv
// Two-input round-robin arbiter; when both ports request, the one that was
// not served last wins.
module iomem_hakem
    import iomem_bellek_yanitlayici_pkg::*;
(
    input  logic v0_i,
    input  logic v1_i,
    input  logic son_hizmet_i,
    input  logic en_i,
    output logic grant_o,
    output logic granted_o
);

    always_comb begin
        grant_o = BIB_PORT;
        if (v0_i && v1_i) begin
            grant_o = ~son_hizmet_i;
        end else if (v1_i) begin
            grant_o = VERI_PORT;
        end
        granted_o = en_i && (v0_i || v1_i);
    end

endmodule

// File: rtl/iomem_bellek_yanitlayici.sv
// iomem bus responder: arbitrates instruction/data cache requests and serves
// them one at a time from a single-port SRAM with optional wait states.
module iomem_bellek_yanitlayici
    import iomem_bellek_yanitlayici_pkg::*;
#(
    parameter int BEKLEME = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       p0_valid_i,
    input  logic [ADR_MSB:ADR_LSB]     p0_addr_i,
    input  logic [31:0]                p0_wdata_i,
    input  logic [3:0]                 p0_wstrb_i,
    output logic [31:0]                p0_rdata_o,
    output logic                       p0_ready_o,
    input  logic                       p1_valid_i,
    input  logic [ADR_MSB:ADR_LSB]     p1_addr_i,
    input  logic [31:0]                p1_wdata_i,
    input  logic [3:0]                 p1_wstrb_i,
    output logic [31:0]                p1_rdata_o,
    output logic                       p1_ready_o,
    output logic                       sram_en_o,
    output logic [3:0]                 sram_we_o,
    output logic [ADR_W-1:0]           sram_adr_o,
    output logic [31:0]                sram_wdata_o,
    input  logic [31:0]                sram_rdata_i
);

    localparam logic [3:0] BEKLEME_L = 4'(BEKLEME);

    logic [1:0]       state_q, state_d;
    logic             grant_q, grant_d;
    logic             son_hizmet_q, son_hizmet_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [3:0]       sayac_q, sayac_d;
    logic             ilk_q, ilk_d;
    logic [31:0]      rdata_q, rdata_d;

    logic hakem_grant;
    logic hakem_granted;

    iomem_hakem u_hakem (
        .v0_i         (p0_valid_i),
        .v1_i         (p1_valid_i),
        .son_hizmet_i (son_hizmet_q),
        .en_i         (state_q == BOSTA),
        .grant_o      (hakem_grant),
        .granted_o    (hakem_granted)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        son_hizmet_d = son_hizmet_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        sayac_d      = sayac_q;
        ilk_d        = ilk_q;
        rdata_d      = rdata_q;
        case (state_q)
            BOSTA: begin
                if (hakem_granted) begin
                    grant_d = hakem_grant;
                    addr_d  = (hakem_grant == VERI_PORT) ? p1_addr_i  : p0_addr_i;
                    wdata_d = (hakem_grant == VERI_PORT) ? p1_wdata_i : p0_wdata_i;
                    wstrb_d = (hakem_grant == VERI_PORT) ? p1_wstrb_i : p0_wstrb_i;
                    state_d = ERISIM;
                end
            end
            ERISIM: begin
                sayac_d = BEKLEME_L;
                ilk_d   = 1'b1;
                state_d = AL;
            end
            AL: begin
                // SRAM data is only valid in the cycle right after the enable
                ilk_d = 1'b0;
                if (ilk_q && (wstrb_q == WSTRB_OKU)) begin
                    rdata_d = sram_rdata_i;
                end
                if (sayac_q != 4'd0) begin
                    sayac_d = sayac_q - 4'd1;
                end else begin
                    state_d = YANIT;
                end
            end
            default: begin
                son_hizmet_d = grant_q;
                state_d      = BOSTA;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BOSTA;
            grant_q      <= BIB_PORT;
            son_hizmet_q <= VERI_PORT;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            sayac_q      <= '0;
            ilk_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            son_hizmet_q <= son_hizmet_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            sayac_q      <= sayac_d;
            ilk_q        <= ilk_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        sram_en_o    = (state_q == ERISIM);
        sram_we_o    = sram_en_o ? wstrb_q : 4'b0000;
        sram_adr_o   = addr_q;
        sram_wdata_o = wdata_q;
        p0_ready_o   = (state_q == YANIT) && (grant_q == BIB_PORT);
        p1_ready_o   = (state_q == YANIT) && (grant_q == VERI_PORT);
        p0_rdata_o   = rdata_q;
        p1_rdata_o   = rdata_q;
    end

endmodule

// File: tb/tb_iomem_bellek_yanitlayici.sv
// Scoreboard bench: two responders (BEKLEME=0 and 3), each with an SRAM model;
// stimulus pushes expected SRAM accesses and ready responses, a monitor checks.
module tb_iomem_bellek_yanitlayici;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;

    logic [1:0]        p0_valid = '0, p1_valid = '0;
    logic [1:0][16:0]  p0_addr = '0, p1_addr = '0;
    logic [1:0][31:0]  p0_wdata = '0, p1_wdata = '0;
    logic [1:0][3:0]   p0_wstrb = '0, p1_wstrb = '0;
    logic [1:0][31:0]  p0_rdata, p1_rdata, sram_wdata;
    logic [1:0]        p0_ready, p1_ready, sram_en;
    logic [1:0][3:0]   sram_we;
    logic [1:0][16:0]  sram_adr;

    logic [1:0]        pre_en = '0;
    logic [16:0]       pre_adr = '0;
    logic [31:0]       pre_dat = '0;

    typedef struct { int g; int port; int cyc; bit rd; logic [31:0] data; } rsp_t;
    typedef struct { int g; int cyc; logic [3:0] we; logic [16:0] adr; logic [31:0] wdata; } acc_t;
    rsp_t rq[$];
    acc_t aq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [logic [16:0]];
        logic [31:0] sram_rdata = '0;

        always @(posedge clk) begin
            if (pre_en[g]) mem[pre_adr] = pre_dat;
            if (sram_en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[g][b]) begin
                        logic [31:0] w;
                        w = mem.exists(sram_adr[g]) ? mem[sram_adr[g]] : 32'h0;
                        w[b*8 +: 8] = sram_wdata[g][b*8 +: 8];
                        mem[sram_adr[g]] = w;
                    end
                sram_rdata <= mem.exists(sram_adr[g]) ? mem[sram_adr[g]] : 32'h0;
            end
        end

        iomem_bellek_yanitlayici #(.BEKLEME(g * 3)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .p0_valid_i   (p0_valid[g]),
            .p0_addr_i    (p0_addr[g]),
            .p0_wdata_i   (p0_wdata[g]),
            .p0_wstrb_i   (p0_wstrb[g]),
            .p0_rdata_o   (p0_rdata[g]),
            .p0_ready_o   (p0_ready[g]),
            .p1_valid_i   (p1_valid[g]),
            .p1_addr_i    (p1_addr[g]),
            .p1_wdata_i   (p1_wdata[g]),
            .p1_wstrb_i   (p1_wstrb[g]),
            .p1_rdata_o   (p1_rdata[g]),
            .p1_ready_o   (p1_ready[g]),
            .sram_en_o    (sram_en[g]),
            .sram_we_o    (sram_we[g]),
            .sram_adr_o   (sram_adr[g]),
            .sram_wdata_o (sram_wdata[g]),
            .sram_rdata_i (sram_rdata)
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Monitor: pops one expectation per SRAM enable and per ready pulse.
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        if (rst_n) begin
            for (int g = 0; g < 2; g++) begin
                if (sram_en[g]) begin
                    if (aq.size() == 0) chk("sram_unexpected", 64'(g), 64'hFF);
                    else begin
                        a = aq.pop_front();
                        chk("sram_inst", 64'(g), 64'(a.g));
                        chk("sram_cycle", 64'(cyc), 64'(a.cyc));
                        chk("sram_we", 64'(sram_we[g]), 64'(a.we));
                        chk("sram_adr", 64'(sram_adr[g]), 64'(a.adr));
                        chk("sram_wdata", 64'(sram_wdata[g]), 64'(a.wdata));
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if ((p == 0) ? p0_ready[g] : p1_ready[g]) begin
                        if (rq.size() == 0) chk("ready_unexpected", 64'(p), 64'hFF);
                        else begin
                            r = rq.pop_front();
                            chk("ready_inst", 64'(g), 64'(r.g));
                            chk("ready_port", 64'(p), 64'(r.port));
                            chk("ready_cycle", 64'(cyc), 64'(r.cyc));
                            if (r.rd) chk("rdata", 64'((p == 0) ? p0_rdata[g] : p1_rdata[g]), 64'(r.data));
                        end
                    end
                end
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drv(input int g, input int p, input bit v, input logic [16:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            p0_valid[g] = v; p0_addr[g] = a; p0_wdata[g] = d; p0_wstrb[g] = s;
        end else begin
            p1_valid[g] = v; p1_addr[g] = a; p1_wdata[g] = d; p1_wstrb[g] = s;
        end
    endtask

    // t = cycle in which the request is first seen in BOSTA (or wins arbitration)
    task automatic expect_acc(input int g, input int p, input int t, input logic [16:0] a,
                              input logic [31:0] d, input logic [3:0] s, input logic [31:0] rdat);
        aq.push_back('{g, t + 1, s, a, d});
        rq.push_back('{g, p, t + 3 + g * 3, (s == 4'b0000), rdat});
    endtask

    task automatic wait_rdy(input int g, input int p);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (p == 0) ? p0_ready[g] : p1_ready[g];
        end
        if (!seen) chk("ready_timeout", 64'(0), 64'(1));
        adv(1);
    endtask

    task automatic preload(input int g, input logic [16:0] a, input logic [31:0] d);
        pre_en = '0; pre_en[g] = 1'b1; pre_adr = a; pre_dat = d;
        adv(1);
        pre_en = '0;
    endtask

    task automatic chk_zero(input int g, input string nm);
        chk({nm, "_ready"}, 64'({p0_ready[g], p1_ready[g]}), 64'(0));
        chk({nm, "_rdata"}, 64'({p0_rdata[g], p1_rdata[g]}), 64'(0));
        chk({nm, "_sram"}, 64'({sram_en[g], sram_we[g], sram_adr[g]}), 64'(0));
        chk({nm, "_wdata"}, 64'(sram_wdata[g]), 64'(0));
    endtask

    initial begin
        int t;
        adv(1);
        preload(0, 17'h00010, 32'hDEADBEEF);
        preload(0, 17'h00200, 32'h22222222);
        preload(1, 17'h00020, 32'h12345678);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        @(negedge clk); rst_n = 1'b1;
        adv(1);

        // read, no wait states
        t = cyc; drv(0, 1, 1, 17'h00010, 0, 4'b0000);
        expect_acc(0, 1, t, 17'h00010, 0, 4'b0000, 32'hDEADBEEF);
        wait_rdy(0, 1); drv(0, 1, 0, 0, 0, 0);

        // byte write with 3 wait states, then read back
        t = cyc; drv(1, 1, 1, 17'h00020, 32'h00AB0000, 4'b0100);
        expect_acc(1, 1, t, 17'h00020, 32'h00AB0000, 4'b0100, 0);
        wait_rdy(1, 1);
        t = cyc; drv(1, 1, 1, 17'h00020, 0, 4'b0000);
        expect_acc(1, 1, t, 17'h00020, 0, 4'b0000, 32'h12AB5678);
        wait_rdy(1, 1); drv(1, 1, 0, 0, 0, 0);

        // contention: p0 first after reset, then p1, then p0 again
        t = cyc;
        drv(0, 0, 1, 17'h00010, 0, 4'b0000);
        drv(0, 1, 1, 17'h00200, 0, 4'b0000);
        expect_acc(0, 0, t, 17'h00010, 0, 4'b0000, 32'hDEADBEEF);
        expect_acc(0, 1, t + 4, 17'h00200, 0, 4'b0000, 32'h22222222);
        wait_rdy(0, 0); drv(0, 0, 0, 0, 0, 0);
        wait_rdy(0, 1); drv(0, 1, 0, 0, 0, 0);
        t = cyc;
        drv(0, 0, 1, 17'h00200, 0, 4'b0000);
        drv(0, 1, 1, 17'h00010, 0, 4'b0000);
        expect_acc(0, 0, t, 17'h00200, 0, 4'b0000, 32'h22222222);
        expect_acc(0, 1, t + 4, 17'h00010, 0, 4'b0000, 32'hDEADBEEF);
        wait_rdy(0, 0); drv(0, 0, 0, 0, 0, 0);
        wait_rdy(0, 1); drv(0, 1, 0, 0, 0, 0);

        // write-back then refill with valid held high, then read back the write
        t = cyc; drv(0, 1, 1, 17'h00100, 32'h11111111, 4'b1111);
        expect_acc(0, 1, t, 17'h00100, 32'h11111111, 4'b1111, 0);
        wait_rdy(0, 1);
        t = cyc; drv(0, 1, 1, 17'h00200, 0, 4'b0000);
        expect_acc(0, 1, t, 17'h00200, 0, 4'b0000, 32'h22222222);
        wait_rdy(0, 1);
        t = cyc; drv(0, 1, 1, 17'h00100, 0, 4'b0000);
        expect_acc(0, 1, t, 17'h00100, 0, 4'b0000, 32'h11111111);
        wait_rdy(0, 1); drv(0, 1, 0, 0, 0, 0);

        // reset during AL: access abandoned, outputs clear without a clock edge
        t = cyc; drv(0, 0, 1, 17'h00010, 0, 4'b0000);
        aq.push_back('{0, t + 1, 4'b0000, 17'h00010, 32'h0});
        adv(2);
        rst_n = 1'b0; drv(0, 0, 0, 0, 0, 0);
        #1 chk_zero(0, "async_reset");
        adv(2);
        @(negedge clk); rst_n = 1'b1;
        adv(1);
        t = cyc; drv(0, 0, 1, 17'h00010, 0, 4'b0000);
        expect_acc(0, 0, t, 17'h00010, 0, 4'b0000, 32'hDEADBEEF);
        wait_rdy(0, 0); drv(0, 0, 0, 0, 0, 0);

        // valid dropped mid-access still completes, then p1 is served normally
        t = cyc; drv(0, 0, 1, 17'h00200, 0, 4'b0000);
        expect_acc(0, 0, t, 17'h00200, 0, 4'b0000, 32'h22222222);
        adv(2); drv(0, 0, 0, 0, 0, 0);
        wait_rdy(0, 0);
        adv(2);
        t = cyc; drv(0, 1, 1, 17'h00010, 0, 4'b0000);
        expect_acc(0, 1, t, 17'h00010, 0, 4'b0000, 32'hDEADBEEF);
        wait_rdy(0, 1); drv(0, 1, 0, 0, 0, 0);

        adv(6);
        chk("rsp_queue_drained", 64'(rq.size()), 64'(0));
        chk("acc_queue_drained", 64'(aq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
